// File: rtl/ex_result_buffer.sv
// Execute-stage output register: W-op sign extension and x0 write suppression
// in front of a two-entry skid buffer, plus a forwarding port from the head entry.
module ex_result_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_result,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic        in_word,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [63:0] fwd_data
);

  // Encoding mirrors the valid bits: bit0 = head valid, bit1 = skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t      state, state_next;
  logic [63:0] h_result, s_result, cap_result;
  logic [4:0]  h_rd, s_rd;
  logic        h_wen, s_wen, cap_wen;
  logic        in_ready_q;
  logic        accept, transfer;
  logic        load_h_in, load_h_skid, load_s;

  always_comb begin
    accept      = in_valid & in_ready_q;
    transfer    = state[0] & out_ready;
    cap_result  = in_word ? {{32{in_result[31]}}, in_result[31:0]} : in_result;
    cap_wen     = in_wen & (in_rd != 5'd0);
    state_next  = state;
    load_h_in   = 1'b0;
    load_h_skid = 1'b0;
    load_s      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          load_h_in  = 1'b1;
        end
      end
      ONE: begin
        if (accept && transfer) begin
          load_h_in = 1'b1;
        end else if (accept) begin
          state_next = FULL;
          load_s     = 1'b1;
        end else if (transfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (transfer) begin
          state_next  = ONE;
          load_h_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Anything accepted alongside a flush is written but left invalid.
    if (flush) state_next = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      h_result   <= 64'd0;
      h_rd       <= 5'd0;
      h_wen      <= 1'b0;
      s_result   <= 64'd0;
      s_rd       <= 5'd0;
      s_wen      <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != FULL);
      if (load_h_in) begin
        h_result <= cap_result;
        h_rd     <= in_rd;
        h_wen    <= cap_wen;
      end else if (load_h_skid) begin
        h_result <= s_result;
        h_rd     <= s_rd;
        h_wen    <= s_wen;
      end
      if (load_s) begin
        s_result <= cap_result;
        s_rd     <= in_rd;
        s_wen    <= cap_wen;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = state[0];
  assign out_result = h_result;
  assign out_rd     = h_rd;
  assign out_wen    = h_wen;
  assign fwd_valid  = state[0] & h_wen;
  assign fwd_rd     = h_rd;
  assign fwd_data   = h_result;

endmodule

// File: tb/tb_ex_result_buffer.sv
// Bench for ex_result_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based model of the two-entry buffer.
module tb_ex_result_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        wen;
  } entry_t;

  entry_t q[$];
  bit     model_ok   = 0;
  bit     reset_data = 0;
  int     compared   = 0;
  int     mismatched = 0;

  ex_result_buffer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_rd(in_rd), .in_wen(in_wen), .in_word(in_word), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the queue model says is held.
  task automatic checkOutput();
    if (!model_ok) return;
    checkBit("in_ready", in_ready, q.size() < 2);
    checkBit("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      checkVal("out_result", out_result, q[0].result);
      checkVal("out_rd", 64'(out_rd), 64'(q[0].rd));
      checkBit("out_wen", out_wen, q[0].wen);
      checkBit("fwd_valid", fwd_valid, q[0].wen);
      checkVal("fwd_rd", 64'(fwd_rd), 64'(q[0].rd));
      checkVal("fwd_data", fwd_data, q[0].result);
    end else begin
      checkBit("fwd_valid_idle", fwd_valid, 1'b0);
      if (reset_data) begin
        checkVal("rst_out_result", out_result, 64'd0);
        checkVal("rst_out_rd", 64'(out_rd), 64'd0);
        checkBit("rst_out_wen", out_wen, 1'b0);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance the model.
  task automatic applyStimulus(input logic r, input logic v, input logic [63:0] res,
                               input logic [4:0] rd, input logic wen, input logic word,
                               input logic fl, input logic ordy);
    entry_t e;
    bit     acc, xfer;
    rst = r; in_valid = v; in_result = res; in_rd = rd;
    in_wen = wen; in_word = word; flush = fl; out_ready = ordy;
    #1;
    checkOutput();
    @(posedge clk);
    acc  = v && (q.size() < 2);
    xfer = ordy && (q.size() > 0);
    if (r) begin
      q.delete();
      model_ok   = 1;
      reset_data = 1;
    end else begin
      if (xfer) void'(q.pop_front());
      if (acc) begin
        e.result   = word ? 64'($signed(res[31:0])) : res;
        e.rd       = rd;
        e.wen      = wen && (rd != 0);
        q.push_back(e);
        reset_data = 0;
      end
      if (fl) q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_rd = '0;
    in_wen = 1'b0; in_word = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    applyStimulus(1, 0, 64'd0, 5'd0, 0, 0, 0, 0);
    applyStimulus(1, 1, 64'hDEAD, 5'd3, 1, 0, 1, 1);
    applyStimulus(0, 0, 64'd0, 5'd0, 0, 0, 0, 0);
    checkBit("reset_out_valid", out_valid, 1'b0);
    checkBit("reset_in_ready", in_ready, 1'b1);
    checkVal("reset_out_result", out_result, 64'd0);

    // W-op sign extension, then the same value as a full-width op
    applyStimulus(0, 1, 64'h0000_0000_8000_0001, 5'd5, 1, 1, 0, 1);
    checkVal("wop_sext", out_result, 64'hFFFF_FFFF_8000_0001);
    checkVal("wop_rd", 64'(out_rd), 64'd5);
    checkBit("wop_fwd_valid", fwd_valid, 1'b1);
    applyStimulus(0, 1, 64'h0000_0000_8000_0001, 5'd5, 1, 0, 0, 1);
    checkVal("nonw_result", out_result, 64'h0000_0000_8000_0001);

    // x0 destination never forwards or writes
    applyStimulus(0, 1, 64'h1234, 5'd0, 1, 0, 0, 1);
    checkBit("x0_out_valid", out_valid, 1'b1);
    checkBit("x0_out_wen", out_wen, 1'b0);
    checkBit("x0_fwd_valid", fwd_valid, 1'b0);
    applyStimulus(0, 0, 64'd0, 5'd0, 0, 0, 0, 1);

    // Backpressure: A and B are held, C waits upstream until space frees
    applyStimulus(0, 1, 64'd1, 5'd1, 1, 0, 0, 0);
    applyStimulus(0, 1, 64'd2, 5'd2, 1, 0, 0, 0);
    checkBit("skid_in_ready_low", in_ready, 1'b0);
    checkVal("skid_head_a", out_result, 64'd1);
    applyStimulus(0, 1, 64'd3, 5'd3, 1, 0, 0, 0);
    checkVal("skid_hold_a", out_result, 64'd1);
    applyStimulus(0, 1, 64'd3, 5'd3, 1, 0, 0, 1);
    checkVal("skid_head_b", out_result, 64'd2);
    checkBit("skid_in_ready_back", in_ready, 1'b1);
    applyStimulus(0, 1, 64'd3, 5'd3, 1, 0, 0, 1);
    checkVal("skid_head_c", out_result, 64'd3);
    applyStimulus(0, 0, 64'd0, 5'd0, 0, 0, 0, 1);
    checkBit("skid_drained", out_valid, 1'b0);

    // Flush while full with an item on offer
    applyStimulus(0, 1, 64'hA0, 5'd7, 1, 0, 0, 0);
    applyStimulus(0, 1, 64'hA1, 5'd8, 1, 0, 0, 0);
    applyStimulus(0, 1, 64'hA2, 5'd9, 1, 0, 1, 0);
    checkBit("flush_out_valid", out_valid, 1'b0);
    checkBit("flush_in_ready", in_ready, 1'b1);
    applyStimulus(0, 1, 64'h55, 5'd4, 1, 0, 0, 0);
    checkVal("post_flush_head", out_result, 64'h55);
    applyStimulus(0, 0, 64'd0, 5'd0, 0, 0, 0, 1);
    checkBit("post_flush_alone", out_valid, 1'b0);

    // Flush discards an item accepted in the same cycle
    applyStimulus(0, 1, 64'hB0, 5'd6, 1, 0, 1, 0);
    checkBit("flush_discard", out_valid, 1'b0);

    // Reset while full
    applyStimulus(0, 1, 64'hC0, 5'd10, 1, 0, 0, 0);
    applyStimulus(0, 1, 64'hC1, 5'd11, 1, 0, 0, 0);
    applyStimulus(1, 1, 64'hC2, 5'd12, 1, 0, 1, 1);
    checkBit("midrst_out_valid", out_valid, 1'b0);
    checkBit("midrst_in_ready", in_ready, 1'b1);
    checkVal("midrst_out_result", out_result, 64'd0);
    checkVal("midrst_out_rd", 64'(out_rd), 64'd0);
    applyStimulus(0, 1, 64'h77, 5'd13, 1, 0, 0, 0);
    checkVal("restart_head", out_result, 64'h77);
    applyStimulus(0, 0, 64'd0, 5'd0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, v, w, wd, fl, ordy;
      logic [63:0] res;
      logic [4:0]  rd;
      r    = ($urandom_range(0, 199) == 0);
      v    = ($urandom_range(0, 9) < 7);
      w    = $urandom_range(0, 1) == 1;
      wd   = $urandom_range(0, 1) == 1;
      fl   = ($urandom_range(0, 29) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      res  = {$urandom, $urandom};
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      applyStimulus(r, v, res, rd, w, wd, fl, ordy);
    end
    applyStimulus(0, 0, 64'd0, 5'd0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
